// File: rtl/usb_rx_edge_filter.sv
`default_nettype none
// ============================================================================
//  Module   : usb_rx_edge_filter
//  Purpose  : Per-channel synchroniser, run-length glitch filter and
//             mode-selectable edge qualifier for USB receive line inputs.
//  Revision : 1.0  initial release
// ============================================================================
module usb_rx_edge_filter #(
    parameter int   NUM_CH      = 2,
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_LEN    = 2,
    parameter logic IDLE_VAL    = 1'b1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [NUM_CH-1:0] line_in,
    input  logic [1:0]        mode,
    input  logic              clear,
    output logic [NUM_CH-1:0] filt_out,
    output logic [NUM_CH-1:0] edge_pulse,
    output logic [NUM_CH-1:0] edge_sticky,
    output logic              edge_any,
    output logic [NUM_CH-1:0] glitch
);

    localparam int              CNT_W     = $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    localparam logic [1:0] C_MODE_RISE = 2'b01;
    localparam logic [1:0] C_MODE_FALL = 2'b10;
    localparam logic [1:0] C_MODE_ANY  = 2'b11;

    logic [NUM_CH-1:0] r_filt;
    logic [NUM_CH-1:0] r_pulse;
    logic [NUM_CH-1:0] r_sticky;
    logic [NUM_CH-1:0] r_glitch;
    logic              r_any;

    logic [NUM_CH-1:0] w_s;
    logic [NUM_CH-1:0] w_upd;
    logic [NUM_CH-1:0] w_glitch_nxt;
    logic [NUM_CH-1:0] w_pulse_nxt;
    logic [NUM_CH-1:0] w_sticky_nxt;
    logic [NUM_CH-1:0] w_filt_nxt;

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic [CNT_W-1:0]       r_cnt;
            logic                   w_differ;

            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    r_sync <= {SYNC_STAGES{IDLE_VAL}};
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], line_in[i]};
                end
            end

            assign w_s[i]          = r_sync[SYNC_STAGES-1];
            assign w_differ        = (w_s[i] != r_filt[i]);
            assign w_upd[i]        = w_differ && (r_cnt == C_CNT_MAX);
            // A run that collapses back to the current level before reaching
            // FILT_LEN samples is reported as a glitch when it ends.
            assign w_glitch_nxt[i] = !w_differ && (r_cnt != '0);

            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    r_cnt <= '0;
                end else if (!w_differ || w_upd[i]) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + C_CNT_ONE;
                end
            end
        end
    endgenerate

    // Mode is only consulted on the cycle a new level is accepted.
    always_comb begin
        w_pulse_nxt = '0;
        case (mode)
            C_MODE_RISE: w_pulse_nxt = w_upd & w_s;
            C_MODE_FALL: w_pulse_nxt = w_upd & ~w_s;
            C_MODE_ANY:  w_pulse_nxt = w_upd;
            default:     w_pulse_nxt = '0;
        endcase
    end

    assign w_filt_nxt   = (r_filt & ~w_upd) | (w_s & w_upd);
    assign w_sticky_nxt = (r_sticky & ~{NUM_CH{clear}}) | w_pulse_nxt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_filt   <= {NUM_CH{IDLE_VAL}};
            r_pulse  <= '0;
            r_sticky <= '0;
            r_glitch <= '0;
            r_any    <= 1'b0;
        end else begin
            r_filt   <= w_filt_nxt;
            r_pulse  <= w_pulse_nxt;
            r_sticky <= w_sticky_nxt;
            r_glitch <= w_glitch_nxt;
            r_any    <= |w_pulse_nxt;
        end
    end

    assign filt_out    = r_filt;
    assign edge_pulse  = r_pulse;
    assign edge_sticky = r_sticky;
    assign glitch      = r_glitch;
    assign edge_any    = r_any;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_edge_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usb_rx_edge_filter
//  Purpose  : Self-checking bench for usb_rx_edge_filter (FILT_LEN 2 and 3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_usb_rx_edge_filter;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [1:0] line_in = 2'b11;
    logic [1:0] mode = 2'b00;
    logic       clear = 1'b0;

    logic [1:0] filt_a, pulse_a, sticky_a, glitch_a;
    logic       any_a;
    logic [1:0] filt_b, pulse_b, sticky_b, glitch_b;
    logic       any_b;

    int checks = 0;
    int errors = 0;

    usb_rx_edge_filter dut (
        .clk(clk), .n_rst(n_rst), .line_in(line_in), .mode(mode), .clear(clear),
        .filt_out(filt_a), .edge_pulse(pulse_a), .edge_sticky(sticky_a),
        .edge_any(any_a), .glitch(glitch_a)
    );

    usb_rx_edge_filter #(.FILT_LEN(3)) dut3 (
        .clk(clk), .n_rst(n_rst), .line_in(line_in), .mode(mode), .clear(clear),
        .filt_out(filt_b), .edge_pulse(pulse_b), .edge_sticky(sticky_b),
        .edge_any(any_b), .glitch(glitch_b)
    );

    always #5 clk = ~clk;

    // Reference model: index 0 tracks FILT_LEN=2, index 1 tracks FILT_LEN=3.
    logic [1:0] q[$];
    logic [1:0] m_filt[2], m_pulse[2], m_sticky[2], m_glitch[2];
    logic       m_any[2];
    int         m_run[2][2];

    function automatic int fl(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    task automatic model_reset();
        q.delete();
        repeat (SYNC) q.push_back(2'b11);
        for (int d = 0; d < 2; d++) begin
            m_filt[d] = 2'b11; m_pulse[d] = 2'b00; m_sticky[d] = 2'b00;
            m_glitch[d] = 2'b00; m_any[d] = 1'b0;
            m_run[d][0] = 0; m_run[d][1] = 0;
        end
    endtask

    task automatic model_edge();
        logic [1:0] s, np, ng;
        s = q[0];
        void'(q.pop_front());
        q.push_back(line_in);
        for (int d = 0; d < 2; d++) begin
            np = 2'b00; ng = 2'b00;
            for (int c = 0; c < 2; c++) begin
                if (s[c] == m_filt[d][c]) begin
                    ng[c] = (m_run[d][c] > 0);
                    m_run[d][c] = 0;
                end else if (m_run[d][c] + 1 >= fl(d)) begin
                    m_filt[d][c] = s[c];
                    m_run[d][c] = 0;
                    np[c] = (mode == 2'b11) || (mode == 2'b01 && s[c]) ||
                            (mode == 2'b10 && !s[c]);
                end else begin
                    m_run[d][c] = m_run[d][c] + 1;
                end
            end
            m_sticky[d] = (m_sticky[d] & ~{2{clear}}) | np;
            m_pulse[d]  = np;
            m_glitch[d] = ng;
            m_any[d]    = |np;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic prep(input logic [1:0] lv, input logic [1:0] md);
        line_in = lv; mode = md; clear = 1'b0;
        repeat (8) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; line_in = 2'b11;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (filt_a !== 2'b11)  begin errors++; $display("FAIL reset_filt got %b exp 11", filt_a); end
        checks++; if (pulse_a !== 2'b00) begin errors++; $display("FAIL reset_pulse got %b exp 00", pulse_a); end
        checks++; if (sticky_a !== 2'b00) begin errors++; $display("FAIL reset_sticky got %b exp 00", sticky_a); end
        checks++; if (any_a !== 1'b0)    begin errors++; $display("FAIL reset_any got %b exp 0", any_a); end
        checks++; if (glitch_a !== 2'b00) begin errors++; $display("FAIL reset_glitch got %b exp 00", glitch_a); end
        checks++; if (filt_b !== 2'b11)  begin errors++; $display("FAIL reset_filt3 got %b exp 11", filt_b); end
        @(negedge clk);
        n_rst = 1'b1;
        model_reset();
    endtask

    task automatic test_any_edge();
        prep(2'b11, 2'b11);
        line_in = 2'b10;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if (filt_a !== 2'b11 || pulse_a !== 2'b00)
                begin errors++; $display("FAIL any_early edge%0d got filt %b pulse %b exp 11 00", k, filt_a, pulse_a); end
        end
        step();
        checks++; if (filt_a !== 2'b10)  begin errors++; $display("FAIL any_filt got %b exp 10", filt_a); end
        checks++; if (pulse_a !== 2'b01) begin errors++; $display("FAIL any_pulse got %b exp 01", pulse_a); end
        checks++; if (any_a !== 1'b1)    begin errors++; $display("FAIL any_any got %b exp 1", any_a); end
        checks++; if (pulse_b !== 2'b00) begin errors++; $display("FAIL any_pulse3_early got %b exp 00", pulse_b); end
        step();
        checks++; if (pulse_a !== 2'b00 || any_a !== 1'b0)
            begin errors++; $display("FAIL any_oneshot got pulse %b any %b exp 00 0", pulse_a, any_a); end
        checks++; if (sticky_a !== 2'b01) begin errors++; $display("FAIL any_sticky got %b exp 01", sticky_a); end
        checks++; if (filt_b !== 2'b10 || pulse_b !== 2'b01)
            begin errors++; $display("FAIL any_len3 got filt %b pulse %b exp 10 01", filt_b, pulse_b); end
    endtask

    task automatic test_glitch();
        int gl, pc, bad;
        prep(2'b11, 2'b11);
        gl = 0; pc = 0; bad = 0;
        line_in = 2'b10;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) line_in = 2'b11;
            step();
            gl += int'(glitch_b[0]); pc += int'(pulse_b[0]); bad += int'(filt_b[0] !== 1'b1);
        end
        checks++; if (gl != 1)  begin errors++; $display("FAIL glitch_count got %0d exp 1", gl); end
        checks++; if (pc != 0)  begin errors++; $display("FAIL glitch_pulse got %0d exp 0", pc); end
        checks++; if (bad != 0) begin errors++; $display("FAIL glitch_filt_moved got %0d exp 0", bad); end
        gl = 0; pc = 0;
        line_in = 2'b10;
        for (int k = 0; k < 8; k++) begin
            step();
            gl += int'(glitch_b[0]); pc += int'(pulse_b[0]);
        end
        checks++; if (filt_b[0] !== 1'b0) begin errors++; $display("FAIL hold3_filt got %b exp 0", filt_b[0]); end
        checks++; if (pc != 1 || gl != 0)
            begin errors++; $display("FAIL hold3_flags got pulses %0d glitches %0d exp 1 0", pc, gl); end
    endtask

    task automatic test_mode_select();
        logic [1:0] ms[3];
        int ef[3], er[3];
        int nf, nr;
        ms[0] = 2'b01; ms[1] = 2'b10; ms[2] = 2'b00;
        ef[0] = 0; er[0] = 1; ef[1] = 1; er[1] = 0; ef[2] = 0; er[2] = 0;
        for (int m = 0; m < 3; m++) begin
            prep(2'b11, ms[m]);
            nf = 0; nr = 0;
            line_in = 2'b01;
            repeat (8) begin step(); nf += int'(pulse_a[1]); end
            checks++; if (filt_a[1] !== 1'b0) begin errors++; $display("FAIL mode%b_fall_filt got %b exp 0", ms[m], filt_a[1]); end
            line_in = 2'b11;
            repeat (8) begin step(); nr += int'(pulse_a[1]); end
            checks++; if (filt_a[1] !== 1'b1) begin errors++; $display("FAIL mode%b_rise_filt got %b exp 1", ms[m], filt_a[1]); end
            checks++; if (nf != ef[m] || nr != er[m])
                begin errors++; $display("FAIL mode%b_pulses got fall %0d rise %0d exp %0d %0d", ms[m], nf, nr, ef[m], er[m]); end
        end
    endtask

    task automatic test_clear_collision();
        prep(2'b11, 2'b11);
        line_in = 2'b10;
        repeat (3) step();
        clear = 1'b1;
        step();
        checks++; if (pulse_a[0] !== 1'b1 || sticky_a[0] !== 1'b1)
            begin errors++; $display("FAIL clr_collide got pulse %b sticky %b exp 1 1", pulse_a[0], sticky_a[0]); end
        step();
        checks++; if (sticky_a[0] !== 1'b0) begin errors++; $display("FAIL clr_alone got %b exp 0", sticky_a[0]); end
        clear = 1'b0;
    endtask

    task automatic test_back_to_back();
        prep(2'b11, 2'b11);
        line_in = 2'b00;
        repeat (3) step();
        step();
        checks++; if (pulse_a !== 2'b11 || any_a !== 1'b1)
            begin errors++; $display("FAIL both_pulse got %b any %b exp 11 1", pulse_a, any_a); end
        step();
        checks++; if (pulse_a !== 2'b00 || any_a !== 1'b0)
            begin errors++; $display("FAIL both_after got %b any %b exp 00 0", pulse_a, any_a); end
    endtask

    task automatic test_reset_midrun();
        int np;
        prep(2'b11, 2'b11);
        line_in = 2'b10;
        repeat (4) step();
        line_in = 2'b11;
        repeat (3) step();
        #2 n_rst = 1'b0;
        #1;
        checks++; if (filt_a !== 2'b11 || pulse_a !== 2'b00 || sticky_a !== 2'b00 || any_a !== 1'b0 || glitch_a !== 2'b00)
            begin errors++; $display("FAIL midrst got filt %b pulse %b sticky %b any %b glitch %b", filt_a, pulse_a, sticky_a, any_a, glitch_a); end
        @(negedge clk);
        n_rst = 1'b1;
        model_reset();
        np = 0;
        repeat (8) begin step(); np += int'(pulse_a != 2'b00) + int'(any_a) + int'(glitch_a != 2'b00); end
        checks++; if (np != 0) begin errors++; $display("FAIL midrst_quiet got %0d events exp 0", np); end
    endtask

    task automatic test_random();
        int hold;
        logic [1:0] gf, gp, gs, gg;
        logic ga;
        hold = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (hold == 0) begin
                line_in = 2'($urandom_range(0, 3));
                hold = $urandom_range(1, 4);
            end
            hold--;
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            clear = ($urandom_range(0, 7) == 0);
            step();
            for (int d = 0; d < 2; d++) begin
                gf = d == 0 ? filt_a : filt_b;   gp = d == 0 ? pulse_a : pulse_b;
                gs = d == 0 ? sticky_a : sticky_b; gg = d == 0 ? glitch_a : glitch_b;
                ga = d == 0 ? any_a : any_b;
                checks++; if (gf !== m_filt[d])   begin errors++; $display("FAIL rnd_filt d%0d cyc %0d got %b exp %b", d, cyc, gf, m_filt[d]); end
                checks++; if (gp !== m_pulse[d])  begin errors++; $display("FAIL rnd_pulse d%0d cyc %0d got %b exp %b", d, cyc, gp, m_pulse[d]); end
                checks++; if (gs !== m_sticky[d]) begin errors++; $display("FAIL rnd_sticky d%0d cyc %0d got %b exp %b", d, cyc, gs, m_sticky[d]); end
                checks++; if (gg !== m_glitch[d]) begin errors++; $display("FAIL rnd_glitch d%0d cyc %0d got %b exp %b", d, cyc, gg, m_glitch[d]); end
                checks++; if (ga !== m_any[d])    begin errors++; $display("FAIL rnd_any d%0d cyc %0d got %b exp %b", d, cyc, ga, m_any[d]); end
            end
        end
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_any_edge();
        test_glitch();
        test_mode_select();
        test_clear_collision();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
